// File: rtl/nano_lsu_hs.sv
// Handshaked load/store unit: one outstanding access, lane steering and load extension.
// Optional ACCESS timeout is enabled by defining NANO_LSU_TIMEOUT_EN.
module nano_lsu_hs #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  output logic [31:0]           d_addr_o,
  output logic [DATA_W-1:0]     d_data_o,
  output logic [DATA_W/8-1:0]   d_we_o,
  output logic                  d_rd_o,
  input  logic                  d_ack_i,
  input  logic [DATA_W-1:0]     d_data_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("nano_lsu_hs: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("nano_lsu_hs: TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t              state_reg, state_next;
  logic                err_reg, err_next;
  logic [31:0]         addr_reg;
  logic [2:0]          funct3_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   cap_reg;

  logic                accept;
  logic                f3_ok;
  logic                align_ok;
  logic                timeout_hit;

  assign accept = (state_reg == ST_IDLE) && req_valid_i;

  // Legality is judged on the incoming request so the FSM can skip ACCESS entirely.
  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we_i;
      3'b011:                 f3_ok = (DATA_W == 64);
      3'b110:                 f3_ok = (DATA_W == 64) && !req_we_i;
      default:                f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    align_ok = 1'b1;
    case (req_funct3_i[1:0])
      2'b01:   align_ok = (req_addr_i[0] == 1'b0);
      2'b10:   align_ok = (req_addr_i[1:0] == 2'b00);
      2'b11:   align_ok = (req_addr_i[2:0] == 3'b000);
      default: align_ok = 1'b1;
    endcase
  end

`ifdef NANO_LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_reg <= '0;
    end else if (accept) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end

  assign timeout_hit = (state_reg == ST_ACCESS) && (tmo_cnt_reg == 8'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_next = (f3_ok && align_ok) ? ST_ACCESS : ST_RESP;
          err_next   = !(f3_ok && align_ok);
        end
      end
      ST_ACCESS: begin
        // An ack on the final allowed cycle still completes normally.
        if (d_ack_i) begin
          state_next = ST_RESP;
          err_next   = 1'b0;
        end else if (timeout_hit) begin
          state_next = ST_RESP;
          err_next   = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        err_next   = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
        err_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      funct3_reg <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      cap_reg    <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (accept) begin
        addr_reg   <= req_addr_i;
        funct3_reg <= req_funct3_i;
        we_reg     <= req_we_i;
        wdata_reg  <= req_wdata_i;
      end
      if (state_reg == ST_ACCESS && d_ack_i) begin
        cap_reg <= d_data_i;
      end
    end
  end

  logic [LANE_W-1:0] lane;
  logic [LANE_W+2:0] shamt;
  logic [STRB_W-1:0] size_mask;
  logic              in_access;

  assign lane      = addr_reg[LANE_W-1:0];
  assign shamt     = {lane, 3'b000};
  assign in_access = (state_reg == ST_ACCESS);

  always_comb begin
    size_mask = '1;
    case (funct3_reg[1:0])
      2'b00:   size_mask = STRB_W'(1);
      2'b01:   size_mask = STRB_W'(3);
      2'b10:   size_mask = STRB_W'(15);
      default: size_mask = '1;
    endcase
  end

  assign req_ready_o = (state_reg == ST_IDLE);
  assign d_addr_o    = in_access ? {addr_reg[31:LANE_W], {LANE_W{1'b0}}} : '0;
  assign d_rd_o      = in_access && !we_reg;
  assign d_we_o      = (in_access && we_reg) ? (size_mask << lane) : '0;
  assign d_data_o    = in_access ? (wdata_reg << shamt) : '0;

  // Load extension: build byte/half/word views bit by bit; funct3[2] selects zero-extend.
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] byte_ext, half_ext, word_ext;
  logic              b_sign, h_sign, w_sign;

  assign ld_shift = cap_reg >> shamt;
  assign b_sign   = !funct3_reg[2] && ld_shift[7];
  assign h_sign   = !funct3_reg[2] && ld_shift[15];
  assign w_sign   = !funct3_reg[2] && ld_shift[31];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    if (gi < 8) begin : g_b0
      assign byte_ext[gi] = ld_shift[gi];
      assign half_ext[gi] = ld_shift[gi];
      assign word_ext[gi] = ld_shift[gi];
    end else if (gi < 16) begin : g_b1
      assign byte_ext[gi] = b_sign;
      assign half_ext[gi] = ld_shift[gi];
      assign word_ext[gi] = ld_shift[gi];
    end else if (gi < 32) begin : g_b23
      assign byte_ext[gi] = b_sign;
      assign half_ext[gi] = h_sign;
      assign word_ext[gi] = ld_shift[gi];
    end else begin : g_hi
      assign byte_ext[gi] = b_sign;
      assign half_ext[gi] = h_sign;
      assign word_ext[gi] = w_sign;
    end
  end

  assign resp_valid_o = (state_reg == ST_RESP);
  assign resp_err_o   = resp_valid_o && err_reg;

  always_comb begin
    resp_rdata_o = '0;
    if (resp_valid_o && !err_reg && !we_reg) begin
      case (funct3_reg[1:0])
        2'b00:   resp_rdata_o = byte_ext;
        2'b01:   resp_rdata_o = half_ext;
        2'b10:   resp_rdata_o = word_ext;
        default: resp_rdata_o = ld_shift;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_lsu_hs.sv
// Directed bench for nano_lsu_hs: a 32-bit instance (TIMEOUT_CYC=4) and a 64-bit instance.
module tb_nano_lsu_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv32, rv64, ack32, ack64;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, d_rdata;

  logic        rdy32, val32, err32, rd32;
  logic [31:0] rdata32, daddr32, ddata32;
  logic [3:0]  we32;
  logic        rdy64, val64, err64, rd64;
  logic [63:0] rdata64, ddata64;
  logic [31:0] daddr64;
  logic [7:0]  we64;

  always #5 clk = ~clk;

  nano_lsu_hs #(.DATA_W(32), .TIMEOUT_CYC(4)) dut32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv32), .req_ready_o(rdy32),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata[31:0]), .resp_valid_o(val32), .resp_rdata_o(rdata32),
    .resp_err_o(err32), .d_addr_o(daddr32), .d_data_o(ddata32), .d_we_o(we32),
    .d_rd_o(rd32), .d_ack_i(ack32), .d_data_i(d_rdata[31:0])
  );

  nano_lsu_hs #(.DATA_W(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv64), .req_ready_o(rdy64),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(val64), .resp_rdata_o(rdata64),
    .resp_err_o(err64), .d_addr_o(daddr64), .d_data_o(ddata64), .d_we_o(we64),
    .d_rd_o(rd64), .d_ack_i(ack64), .d_data_i(d_rdata)
  );

  // Observation mux: the task under way selects which instance it is looking at.
  bit          sel64;
  logic        o_ready, o_valid, o_err, o_rd;
  logic [63:0] o_rdata, o_ddata;
  logic [31:0] o_daddr;
  logic [7:0]  o_we;
  assign o_ready = sel64 ? rdy64 : rdy32;
  assign o_valid = sel64 ? val64 : val32;
  assign o_err   = sel64 ? err64 : err32;
  assign o_rd    = sel64 ? rd64 : rd32;
  assign o_rdata = sel64 ? rdata64 : {32'h0, rdata32};
  assign o_ddata = sel64 ? ddata64 : {32'h0, ddata32};
  assign o_daddr = sel64 ? daddr64 : daddr32;
  assign o_we    = sel64 ? we64 : {4'h0, we32};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ack(input logic v);
    if (sel64) ack64 = v;
    else ack32 = v;
  endtask

  typedef struct {
    bit          is64;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          wait_n;
    logic [63:0] din;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic [7:0]  exp_we;
    logic [63:0] exp_data;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[20];

  task automatic run_vec(input int idx, input vec_t v);
    sel64 = v.is64;
    req_we = v.we; req_f3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    if (v.is64) rv64 = 1'b1;
    else rv32 = 1'b1;
    tick();
    rv32 = 1'b0; rv64 = 1'b0;
    if (v.exp_err) begin
      check("err_valid", o_valid, 1);
      check("err_flag", o_err, 1);
      check("err_rdata", o_rdata, 0);
      check("err_no_rd", o_rd, 0);
      check("err_no_we", o_we, 0);
    end else begin
      for (int w = 0; w <= v.wait_n; w++) begin
        check("acc_addr", o_daddr, v.exp_addr);
        check("acc_we", o_we, v.exp_we);
        check("acc_rd", o_rd, !v.we);
        check("acc_data", o_ddata, v.exp_data);
        check("acc_no_resp", o_valid, 0);
        if (w == v.wait_n) begin
          set_ack(1'b1);
          d_rdata = v.din;
        end
        tick();
        set_ack(1'b0);
      end
      check("resp_valid", o_valid, 1);
      check("resp_err", o_err, 0);
      check("resp_rdata", o_rdata, v.exp_rdata);
      check("resp_bus_idle", o_rd | (|o_we), 0);
    end
    tick();
    check("post_valid", o_valid, 0);
    check("post_ready", o_ready, 1);
    $display("txn %0d: dw=%0d we=%0d f3=%03b addr=%h rdata=%h err=%0d",
             idx, v.is64 ? 64 : 32, v.we, v.f3, v.addr, v.exp_rdata, v.exp_err);
  endtask

  int stuck_cnt;

  initial begin
    rst = 1'b1; rv32 = 1'b0; rv64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
    req_we = 1'b0; req_f3 = 3'b0; req_addr = '0; req_wdata = '0; d_rdata = '0;
    sel64 = 1'b0;

    //          is64 we f3      addr          wdata                   wait din                      err exp_rdata               we     data                    addr
    vecs[0]  = '{0, 0, 3'b000, 32'h103, 64'h0,                 0, 64'h80FF_FF00,          0, 64'hFFFF_FF80,          8'h0,  64'h0,                 32'h100};
    vecs[1]  = '{0, 1, 3'b001, 32'h202, 64'h1234_ABCD,         3, 64'h0,                  0, 64'h0,                  8'hC,  64'hABCD_0000,         32'h200};
    vecs[2]  = '{0, 0, 3'b010, 32'h301, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[3]  = '{0, 0, 3'b011, 32'h300, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[4]  = '{0, 0, 3'b100, 32'h101, 64'h0,                 1, 64'h1234_8056,          0, 64'h80,                 8'h0,  64'h0,                 32'h100};
    vecs[5]  = '{0, 0, 3'b101, 32'h102, 64'h0,                 0, 64'h9ABC_0000,          0, 64'h9ABC,               8'h0,  64'h0,                 32'h100};
    vecs[6]  = '{0, 0, 3'b001, 32'h102, 64'h0,                 2, 64'h9ABC_0000,          0, 64'hFFFF_9ABC,          8'h0,  64'h0,                 32'h100};
    vecs[7]  = '{0, 0, 3'b010, 32'h104, 64'h0,                 0, 64'hDEAD_BEEF,          0, 64'hDEAD_BEEF,          8'h0,  64'h0,                 32'h104};
    vecs[8]  = '{0, 1, 3'b000, 32'h001, 64'hA5,                1, 64'h0,                  0, 64'h0,                  8'h2,  64'hA500,              32'h0};
    vecs[9]  = '{0, 1, 3'b010, 32'h008, 64'hCAFE_F00D,         0, 64'h0,                  0, 64'h0,                  8'hF,  64'hCAFE_F00D,         32'h8};
    vecs[10] = '{0, 0, 3'b111, 32'h000, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[11] = '{0, 1, 3'b100, 32'h000, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[12] = '{0, 0, 3'b001, 32'h101, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[13] = '{0, 0, 3'b110, 32'h100, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[14] = '{1, 0, 3'b110, 32'h404, 64'h0,                 0, 64'hF000_0001_0000_0000, 0, 64'h0000_0000_F000_0001, 8'h0, 64'h0,                 32'h400};
    vecs[15] = '{1, 1, 3'b011, 32'h408, 64'h0123_4567_89AB_CDEF, 1, 64'h0,                0, 64'h0,                  8'hFF, 64'h0123_4567_89AB_CDEF, 32'h408};
    vecs[16] = '{1, 0, 3'b010, 32'h404, 64'h0,                 0, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_8000_0000, 8'h0, 64'h0,                 32'h400};
    vecs[17] = '{1, 1, 3'b001, 32'h406, 64'hBEEF,              0, 64'h0,                  0, 64'h0,                  8'hC0, 64'hBEEF_0000_0000_0000, 32'h400};
    vecs[18] = '{1, 1, 3'b011, 32'h404, 64'h0,                 0, 64'h0,                  1, 64'h0,                  8'h0,  64'h0,                 32'h0};
    vecs[19] = '{1, 0, 3'b011, 32'h408, 64'h0,                 2, 64'h1122_3344_5566_7788, 0, 64'h1122_3344_5566_7788, 8'h0, 64'h0,                 32'h408};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      check("rst_ready", o_ready, 1);
      check("rst_valid", o_valid, 0);
      check("rst_err", o_err, 0);
      check("rst_rdata", o_rdata, 0);
      check("rst_bus", {o_rd, o_we, o_daddr} | {33'h0, o_ddata[31:0]} | {33'h0, o_ddata[63:32]}, 0);
    end

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // Ack while idle must not produce a response.
    sel64 = 1'b0;
    ack32 = 1'b1; d_rdata = 64'hFFFF_FFFF;
    tick();
    check("idle_ack_valid", o_valid, 0);
    check("idle_ack_ready", o_ready, 1);
    ack32 = 1'b0;
    $display("txn idle_ack: ack in IDLE ignored");

    // Request held during ACCESS/RESP waits and is taken once back in IDLE.
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h10; rv32 = 1'b1;
    tick();
    check("pend_ready_acc", o_ready, 0);
    check("pend_rd", o_rd, 1);
    ack32 = 1'b1; d_rdata = 64'h1111_1111;
    tick();
    ack32 = 1'b0;
    check("pend_ready_resp", o_ready, 0);
    check("pend_rdata1", o_rdata, 64'h1111_1111);
    tick();
    check("pend_idle_ready", o_ready, 1);
    tick();
    rv32 = 1'b0;
    check("pend_accepted", o_rd, 1);
    ack32 = 1'b1; d_rdata = 64'h2222_2222;
    tick();
    ack32 = 1'b0;
    check("pend_rdata2", o_rdata, 64'h2222_2222);
    tick();
    $display("txn pending: held request accepted after RESP");

`ifdef NANO_LSU_TIMEOUT_EN
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h20; rv32 = 1'b1;
    tick();
    rv32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_access_rd", o_rd, 1);
      check("tmo_no_resp", o_valid, 0);
      tick();
    end
    check("tmo_valid", o_valid, 1);
    check("tmo_err", o_err, 1);
    check("tmo_rdata", o_rdata, 0);
    ack32 = 1'b1; d_rdata = 64'h5555_5555;
    tick();
    check("late_ack_valid", o_valid, 0);
    check("late_ack_ready", o_ready, 1);
    ack32 = 1'b0;
    $display("txn timeout: err after 4 ACCESS cycles");
`else
    req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h20; rv32 = 1'b1;
    tick();
    rv32 = 1'b0;
    stuck_cnt = 0;
    repeat (100) begin
      if (o_rd && !o_valid) stuck_cnt++;
      tick();
    end
    check("noto_stuck_cycles", stuck_cnt, 100);
    check("noto_still_rd", o_rd, 1);
    ack32 = 1'b1; d_rdata = 64'h7;
    tick();
    ack32 = 1'b0;
    check("noto_valid", o_valid, 1);
    check("noto_rdata", o_rdata, 64'h7);
    tick();
    $display("txn no_timeout: ACCESS held for 100 cycles");
`endif

    // Reset on the 2nd ACCESS edge, coinciding with an ack.
    req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h40; req_wdata = 64'hFFFF_FFFF; rv32 = 1'b1;
    tick();
    rv32 = 1'b0;
    check("rst_mid_we", o_we, 8'hF);
    tick();
    rst = 1'b1; ack32 = 1'b1;
    tick();
    rst = 1'b0; ack32 = 1'b0;
    check("rst_mid_ready", o_ready, 1);
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_rd", o_rd, 0);
    check("rst_mid_we0", o_we, 0);
    check("rst_mid_addr", o_daddr, 0);
    check("rst_mid_data", o_ddata, 0);
    tick();
    check("rst_mid_no_resp", o_valid, 0);
    $display("txn reset_mid_access: returned to IDLE without response");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
